// File: rtl/dbus_mem_responder_if.sv
// Data-bus link between the core (master) and the on-chip memory responder (slave).
// The master holds req and the request fields stable until it sees ready.
interface dbus_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, mask, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, mask, output rdata, ready, err);
endinterface

// File: rtl/dbus_mem_responder.sv
// Word-organised on-chip memory on the core data bus: byte-lane writes, programmable
// wait states, and a one-cycle ready/err response strobe.
module dbus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  dbus_mem_responder_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          we_reg, hit_reg;
  logic [AW-1:0] idx_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    mask_reg;

  logic [31:0]   off;
  logic          hit;
  logic [AW-1:0] idx;
  logic          enter_resp, mem_en;
  logic          use_live, txn_we, txn_hit;
  logic [AW-1:0] txn_idx;
  logic [31:0]   txn_wdata;
  logic [3:0]    txn_mask;
  logic [31:0]   rdata_q;

  assign off = bus.addr - BASE_ADDR;
  assign hit = {1'b0, off} < SPAN;
  assign idx = off[AW+1:2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req) begin
          if (LATENCY == 0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.req) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // With zero wait states the transaction is committed at the accepting edge, so the
  // live bus fields stand in for the not-yet-latched copies.
  assign use_live  = (state_reg == ST_IDLE);
  assign txn_we    = use_live ? bus.we    : we_reg;
  assign txn_hit   = use_live ? hit       : hit_reg;
  assign txn_idx   = use_live ? idx       : idx_reg;
  assign txn_wdata = use_live ? bus.wdata : wdata_reg;
  assign txn_mask  = use_live ? bus.mask  : mask_reg;
  assign mem_en    = enter_resp & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      hit_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= 32'd0;
      mask_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_IDLE && bus.req) begin
        we_reg    <= bus.we;
        hit_reg   <= hit;
        idx_reg   <= idx;
        wdata_reg <= bus.wdata;
        mask_reg  <= bus.mask;
      end
    end
  end

  // One byte-wide array per lane so each lane maps onto a plain RAM with its own write enable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (mem_en && txn_we && txn_hit && txn_mask[gi])
          mem[txn_idx] <= txn_wdata[8*gi +: 8];
        if (mem_en)
          q_reg <= mem[txn_idx];
      end
      assign rdata_q[8*gi +: 8] = q_reg;
    end
  endgenerate

  assign bus.ready = (state_reg == ST_RESP);
  assign bus.err   = (state_reg == ST_RESP) & ~hit_reg;
  assign bus.rdata = (state_reg == ST_RESP && hit_reg && !we_reg) ? rdata_q : 32'd0;
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Randomised self-checking bench: three responders (0, 1 and 3 wait states) against a byte-level memory model.
module tb_dbus_mem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  mask = 4'd0;
  int          sel = 1;
  logic [31:0] o_rdata;
  logic        o_ready, o_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [bit [63:0]];

  always #5 clk = ~clk;

  dbus_mem_responder_if bus_l0 ();
  dbus_mem_responder_if bus_l1 ();
  dbus_mem_responder_if bus_l3 ();

  assign bus_l0.req = req && (sel == 0);
  assign bus_l1.req = req && (sel == 1);
  assign bus_l3.req = req && (sel == 2);
  assign {bus_l0.we, bus_l0.addr, bus_l0.wdata, bus_l0.mask} = {we, addr, wdata, mask};
  assign {bus_l1.we, bus_l1.addr, bus_l1.wdata, bus_l1.mask} = {we, addr, wdata, mask};
  assign {bus_l3.we, bus_l3.addr, bus_l3.wdata, bus_l3.mask} = {we, addr, wdata, mask};

  dbus_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_l0 (.clk(clk), .rst(rst), .bus(bus_l0));
  dbus_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(bus_l1));
  dbus_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) dut_l3 (.clk(clk), .rst(rst), .bus(bus_l3));

  always_comb begin
    o_rdata = bus_l1.rdata;
    o_ready = bus_l1.ready;
    o_err   = bus_l1.err;
    if (sel == 0) begin
      o_rdata = bus_l0.rdata; o_ready = bus_l0.ready; o_err = bus_l0.err;
    end else if (sel == 2) begin
      o_rdata = bus_l3.rdata; o_ready = bus_l3.ready; o_err = bus_l3.err;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (sel=%0d addr=%h)", tag, got, exp, sel, addr);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1 : 3;
  endfunction

  function automatic bit [63:0] key_of(input int s, input logic [31:0] byte_off);
    return {32'(s), byte_off};
  endfunction

  // One complete transaction: response must arrive exactly LATENCY+1 edges after acceptance
  // and last a single cycle.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] rd, output logic er);
    logic early;
    int lat;
    lat = lat_of(sel);
    early = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; mask = m;
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      if (o_ready) early = 1'b1;
    end
    @(posedge clk); #1;
    check_val("early_ready", early, 1'b0);
    check_val("ready", o_ready, 1'b1);
    rd = o_rdata;
    er = o_err;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    check_val("ready_pulse", o_ready, 1'b0);
  endtask

  task automatic expect_word(input logic [31:0] a, output logic [31:0] w, output bit known);
    logic [31:0] off;
    off = a - BASE;
    known = 1'b1;
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (mdl.exists(key_of(sel, {off[31:2], 2'b00} + i))) w[8*i +: 8] = mdl[key_of(sel, {off[31:2], 2'b00} + i)];
      else known = 1'b0;
    end
  endtask

  task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] rd);
    logic er, in_rng;
    logic [31:0] off, exp_w;
    bit known;
    off = a - BASE;
    in_rng = (off < DEPTH * 4);
    expect_word(a, exp_w, known);
    txn(w, a, d, m, rd, er);
    $display("txn sel=%0d we=%0d addr=%h wdata=%h mask=%h -> rdata=%h err=%0d", sel, w, a, d, m, rd, er);
    check_val("err", er, !in_rng);
    if (w) begin
      check_val("wr_rdata_zero", rd, 32'd0);
      if (in_rng)
        for (int i = 0; i < 4; i++)
          if (m[i]) mdl[key_of(sel, {off[31:2], 2'b00} + i)] = d[8*i +: 8];
    end else if (!in_rng) begin
      check_val("oor_rdata", rd, 32'd0);
    end else if (known) begin
      check_val("rdata", rd, exp_w);
    end
  endtask

  initial begin
    logic [31:0] rd, exp_w, a;
    bit known;
    int pulses;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_val("rst_ready", o_ready, 1'b0);
      check_val("rst_err", o_err, 1'b0);
      check_val("rst_rdata", o_rdata, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Prefill the words the rest of the bench reads so every read has a known answer.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int wi = 0; wi < 16; wi++) do_op(1'b1, BASE + 32'(4 * wi), $urandom, 4'hF, rd);
      for (int wi = DEPTH - 8; wi < DEPTH; wi++) do_op(1'b1, BASE + 32'(4 * wi), $urandom, 4'hF, rd);
    end

    sel = 1;
    do_op(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd);
    do_op(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd);
    check_val("deadbeef", rd, 32'hDEAD_BEEF);
    do_op(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, rd);
    do_op(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd);
    check_val("byte_lanes", rd, 32'hDE22_BE44);
    do_op(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, rd);
    do_op(1'b0, 32'h8000_0010, 32'h0, 4'hF, rd);
    check_val("mask_zero", rd, 32'hDE22_BE44);

    do_op(1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, rd);
    do_op(1'b1, 32'h8000_4000, 32'h5555_AAAA, 4'hF, rd);
    do_op(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd);
    do_op(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, rd);

    // Zero wait states with req held: accept, respond, bubble, repeated.
    sel = 0;
    do_op(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, rd);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h8000_0010; mask = 4'h0;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check_val("b2b_ready", o_ready, (k % 2 == 0) && (k < 6));
      if (o_ready) begin
        pulses++;
        check_val("b2b_rdata", o_rdata, 32'hCAFE_F00D);
        check_val("b2b_addr", addr, 32'h8000_0010);
      end
      if (k == 4) begin
        @(negedge clk);
        req = 1'b0;
      end
    end
    check_val("b2b_pulses", pulses, 3);

    // Abort during wait states: the write must never land.
    sel = 2;
    do_op(1'b1, 32'h8000_0020, 32'h0BAD_0BAD, 4'hF, rd);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8000_0020; wdata = 32'hA5A5_A5A5; mask = 4'hF;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("abort_no_ready", o_ready, 1'b0);
    end
    @(negedge clk);
    req = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check_val("abort_idle", o_ready, 1'b0);
    end
    do_op(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd);
    check_val("abort_prior", rd, 32'h0BAD_0BAD);

    // Reset during a response must clear the outputs without a clock edge.
    sel = 1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h8000_0010; mask = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    check_val("pre_rst_ready", o_ready, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_val("async_rst_ready", o_ready, 1'b0);
    check_val("async_rst_rdata", o_rdata, 32'd0);
    check_val("async_rst_err", o_err, 1'b0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;

    // Reset during wait states of a write: the write is abandoned.
    sel = 2;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8000_0020; wdata = 32'h1234_5678; mask = 4'hF;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_val("wait_rst_ready", o_ready, 1'b0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd);
    check_val("rst_prior", rd, 32'h0BAD_0BAD);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0, 1: a = BASE + 32'(4 * $urandom_range(0, 15));
        2:    a = BASE + 32'(DEPTH * 4) - 32'(4 * $urandom_range(1, 8));
        3:    a = BASE - 32'(4 * $urandom_range(1, 4));
        default: a = $urandom;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    sel = 1;
    expect_word(32'h8000_0010, exp_w, known);
    do_op(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Responder end of the core's simple req/we/addr/data/mask data-bus interface.
- Replaces DPI memory for synthesizable builds: word-organised on-chip memory with byte-lane writes, a programmable wait-state counter, and a registered ready/err response.
- Sits in the top-level SoC, directly on the core's dbus master port.
- The core holds the request stable until the responder returns ready.

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address decoded by the block.
- DEPTH_WORDS, 4096, number of 32-bit words in the memory array; must be a power of two.
- LATENCY, 1, wait states inserted before the response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- I_req  input  1  request valid; held high by the master until O_ready is sampled high
- I_we  input  1  1 = write, 0 = read; stable while I_req is high
- I_addr  input  32  byte address; bits [1:0] are ignored
- I_data  input  32  write data
- I_mask  input  4  byte-lane enables; bit i selects I_data[8i+7:8i]
- O_data  output  32  read data, valid only while O_ready=1
- O_ready  output  1  one-cycle response strobe
- O_err  output  1  address out of range; valid only while O_ready=1

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, counter cleared, O_ready=0, O_err=0, O_data=0. Memory contents are not reset.
- Address decode:
  - off = I_addr - BASE_ADDR, 32-bit modulo arithmetic.
  - In range iff off < DEPTH_WORDS*4 (unsigned compare).
  - Word index = off[log2(DEPTH_WORDS)+1:2].
- FSM states:
  - IDLE: O_ready=0. At a clock edge with I_req=1, latch we/addr/data/mask and the range result. Go to RESP if LATENCY==0; otherwise go to WAIT with cnt=LATENCY-1.
  - WAIT: at each edge, if I_req=0 return to IDLE (abort: no write, no response). Else if cnt==0 go to RESP; else decrement cnt.
  - RESP: O_ready=1 for exactly one cycle, O_err = latched out-of-range flag. Next state is always IDLE.
- Response timing: the request is first sampled at edge E0. O_ready is high in the cycle after edge E0+LATENCY. Request-to-ready latency is LATENCY+1 cycles.
- Throughput: at most one transaction per LATENCY+2 cycles. The IDLE bubble after RESP is mandatory, so a held I_req is never double-accepted.
- Writes:
  - Committed at the edge that enters RESP, using the latched address, data and mask.
  - Only lanes with mask bit 1 are updated; mask 4'b0000 writes nothing but still responds.
  - Out-of-range write: no array update, O_err=1.
  - O_data=0 during a write response.
- Reads:
  - Array read at the edge entering RESP; registered into O_data.
  - Mask is ignored for reads; the full word is returned.
  - Out-of-range read: O_data=32'h0, O_err=1.
- Abort: the master dropping I_req during WAIT discards the transaction. In RESP, a dropped I_req has no effect; the response is still issued.
- Outside RESP: O_data and O_err are driven to 0.
- Latched values are used throughout, so input changes after acceptance do not alter the transaction.
- Reset mid-transaction: abandoned; an uncommitted write never reaches the array.

Test Plan:
- LATENCY=1: write 32'hDEAD_BEEF, mask 4'hF to 32'h8000_0010, then read 32'h8000_0010 -> each O_ready is a single-cycle pulse 2 cycles after req; read returns O_data=32'hDEAD_BEEF, O_err=0.
- Byte lanes: after the above, write 32'h1122_3344 with mask 4'b0101 to the same address, then read -> O_data=32'hDE22_BE44.
- Out of range: read 32'h7FFF_FFFC, then write to 32'h8000_4000 (DEPTH_WORDS=4096) -> both responses have O_err=1; read O_data=0; the array is unchanged (word 0 and word 4095 rechecked).
- LATENCY=0 back-to-back: I_req held high across 3 reads -> O_ready high every 2nd cycle, exactly 3 pulses, addresses unchanged between pulses.
- Abort: LATENCY=3, write 32'hA5A5_A5A5 to 32'h8000_0020; drop I_req after 2 cycles -> no O_ready; a subsequent read of 32'h8000_0020 returns the prior contents.
- Reset: assert rst=0 asynchronously in WAIT during a write -> O_ready/O_err/O_data go to 0 immediately without a clock edge; after release the first read of that address returns the old value and responds with normal latency.
